// File: rtl/benes_4_pipe_pkg.sv
// benes_4_pipe_pkg: shared config type, switch-state encoding and cfg bit indexing for the 4-lane Benes network.
package benes_4_pipe_pkg;
    localparam int CFG_W = 6;
    typedef logic [CFG_W-1:0] cfg_t;
    localparam logic SW_BAR   = 1'b1;
    localparam logic SW_CROSS = 1'b0;
    function automatic int cfg_idx(input int r, input int c);
        return r * 3 + c;
    endfunction
endpackage

// File: rtl/benes_4_pipe_sw2.sv
// benes_sw2: combinational 2x2 switch; ports a/b lane inputs, s state (bar/cross), y0/y1 upper/lower outputs.
module benes_sw2
    import benes_4_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1
);
    assign y0 = (s == SW_BAR) ? a : b;
    assign y1 = (s == SW_BAR) ? b : a;
endmodule

// File: rtl/benes_4_pipe.sv
// benes_4_pipe: 3-stage pipelined 4x4 Benes network with valid/ready handshake; in_* upstream beat and cfg, out_* routed beat, out_err/err_cnt flag invalid configs.
module benes_4_pipe
    import benes_4_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_d0,
    input  logic [W-1:0] in_d1,
    input  logic [W-1:0] in_d2,
    input  logic [W-1:0] in_d3,
    input  logic [5:0]   cfg,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_d0,
    output logic [W-1:0] out_d1,
    output logic [W-1:0] out_d2,
    output logic [W-1:0] out_d3,
    output logic         out_err,
    output logic [7:0]   err_cnt
);
    // Lane vectors are stored in the order the next column reads them:
    // index 2*row+input of the following switch column.
    logic [3:0][W-1:0] din, n0, q0, n1, q1, n2, q2;
    logic [3:0]        cq0;
    logic [1:0]        cq1;
    logic              v0, v1, v2, e0, e1, e2;
    logic              ld0, ld1, ld2, in_err;
    cfg_t              cfg_in;

    assign cfg_in = cfg;
    assign din    = {in_d3, in_d2, in_d1, in_d0};
    assign in_err = cfg_in[cfg_idx(0, 0)] == SW_CROSS;

    assign ld2      = !v2 || out_ready;
    assign ld1      = !v1 || ld2;
    assign ld0      = !v0 || ld1;
    assign in_ready = ld0;

    genvar r;
    generate
        for (r = 0; r < 2; r++) begin : g_row
            benes_sw2 #(.W(W)) u_c0 (
                .a(din[2*r]), .b(din[2*r+1]), .s(cfg_in[cfg_idx(r, 0)]),
                .y0(n0[r]), .y1(n0[2+r])
            );
            benes_sw2 #(.W(W)) u_c1 (
                .a(q0[2*r]), .b(q0[2*r+1]), .s(cq0[r]),
                .y0(n1[r]), .y1(n1[2+r])
            );
            benes_sw2 #(.W(W)) u_c2 (
                .a(q1[2*r]), .b(q1[2*r+1]), .s(cq1[r]),
                .y0(n2[2*r]), .y1(n2[2*r+1])
            );
        end
    endgenerate

    // Data and the switch bits still ahead of the beat travel together.
    always_ff @(posedge clk) begin
        if (ld0) begin
            q0  <= n0;
            cq0 <= {cfg_in[cfg_idx(1, 2)], cfg_in[cfg_idx(0, 2)],
                    cfg_in[cfg_idx(1, 1)], cfg_in[cfg_idx(0, 1)]};
        end
        if (ld1) begin
            q1  <= n1;
            cq1 <= cq0[3:2];
        end
        if (ld2) q2 <= n2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {v0, v1, v2, e0, e1, e2} <= '0;
            err_cnt <= '0;
        end else begin
            if (ld0) {v0, e0} <= {in_valid, in_err};
            if (ld1) {v1, e1} <= {v0, e0};
            if (ld2) {v2, e2} <= {v1, e1};
            if (in_valid && ld0 && in_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

    assign out_valid = v2;
    assign out_err   = e2;
    assign {out_d3, out_d2, out_d1, out_d0} = q2;
endmodule

// File: doc/benes_4_pipe.md
BENES_4_PIPE -- requirements
Module: benes_4_pipe

Interface
REQ-001 Parameter W, default 8, data width of each of the four lanes.
REQ-002 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port in_valid, input, 1, upstream beat valid.
REQ-005 Port in_ready, output, 1, block can accept a beat this cycle.
REQ-006 Port in_d0..in_d3, input, W each, lane data, lane k = network input k.
REQ-007 Port cfg, input, 6, switch states: cfg[r*3+c] = state of switch row r (0..1), column c (0..2), from the permutation control lookup.
REQ-008 Port out_valid, output, 1, output beat valid.
REQ-009 Port out_ready, input, 1, downstream accepts the beat.
REQ-010 Port out_d0..out_d3, output, W each, routed lane data.
REQ-011 Port out_err, output, 1, beat was routed with an invalid configuration.
REQ-012 Port err_cnt, output, 8, saturating count of accepted beats with invalid configuration.

Function
REQ-013 Transfers occur on in_valid&&in_ready (input) and out_valid&&out_ready (output); no other beat is consumed or produced.
REQ-014 Three register stages, one per switch column; stage c applies cfg bits {cfg[3+c], cfg[c]}, which travel with the beat.
REQ-015 Switch state 1 = bar (upper in -> upper out, lower in -> lower out); state 0 = cross.
REQ-016 Column 0: row r takes in_d(2r) upper, in_d(2r+1) lower.
REQ-017 Column 0 row r upper out -> column 1 row 0 input r; lower out -> column 1 row 1 input r.
REQ-018 Column 1 row m upper out -> column 2 row 0 input m; lower out -> column 2 row 1 input m.
REQ-019 Column 2 row r upper out -> out_d(2r), lower out -> out_d(2r+1).
REQ-020 Latency exactly 3 cycles from input transfer to out_valid with out_ready held high; throughput one beat per cycle.
REQ-021 Each stage loads when empty or when its downstream stage advances in the same cycle; in_ready = stage-0 load condition, combinational from out_ready allowed.
REQ-022 Stage holds data, cfg and err unchanged while stalled; out_d*/out_err stable while out_valid&&!out_ready.
REQ-023 Invalid configuration = cfg[0]==0 (every legal permutation drives column-0 row-0 to bar; the control lookup outputs all zeros on illegal input); beat still routed, err bit set and carried to out_err.
REQ-024 err_cnt increments by 1 on each input transfer with cfg[0]==0; saturates at 255, no wrap.
REQ-025 Simultaneous input and output transfer with full pipeline: no beat lost or duplicated, order preserved.
REQ-026 Inputs ignored when in_ready low; in_valid may drop without a transfer.

Reset
REQ-027 rst_n low asynchronously clears all stage valid bits, out_valid=0, out_err=0, err_cnt=0; in_ready=1 in the first cycle after release.
REQ-028 Reset mid-operation discards all in-flight beats; data registers need not be cleared.

Structure
REQ-029 Shared package holds the 6-bit config type, index function r*3+c, and the bar/cross encoding constants shared with the control lookup.
REQ-030 One sub-module, benes_sw2: combinational 2x2 switch (two W-bit inputs, one state bit, two outputs), instantiated six times.

Verification
REQ-031 Identity: cfg=6'h3F, in_d0..3=A0,B1,C2,D3 -> 3 cycles later out_d0..3=A0,B1,C2,D3, out_err=0.
REQ-032 Swap 2/3: cfg=6'h1F, same data -> out_d0..3=A0,B1,D3,C2.
REQ-033 Reverse: cfg=6'h09, same data -> out_d0..3=D3,C2,B1,A0.
REQ-034 Backpressure: stream 5 beats, out_ready=0 from cycle 2 -> in_ready drops after 3 beats held, all 5 delivered in order after out_ready=1.
REQ-035 Invalid cfg: 300 beats with cfg=6'h00 -> every out_err=1, err_cnt=255 saturated, output of last beat = cross-all routing.
REQ-036 Reset with 3 beats in flight -> out_valid=0 immediately, err_cnt=0, no stale beat emitted after release.
